// File: rtl/can_tx_mailbox_pkg.sv
// Shared types and constants for the CAN transmit mailbox.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package can_tx_pkg;

    localparam int MAX_BYTES = 8;
    // Widest identifier the block supports (29-bit extended frames).
    localparam int MAX_ID_W  = 29;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        REQ  = 2'd2,
        WAIT = 2'd3
    } state_t;

    // Identifiers are stored zero-extended to MAX_ID_W. This keeps the
    // ordering identical to a native ID_W compare.
    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic                rtr;
        logic [3:0]          dlc;
    } hdr_t;

endpackage

// File: rtl/can_tx_mailbox_if.sv
// Mailbox <-> frame generator link: request/ack plus the selected frame.
// Latency: n/a (wires only).
// Backpressure: frame_gen_intl is held until fg_ack; the result then comes back on tx_success/tx_fail.
// master: mailbox side (drives request and frame); slave: frame generator side.
interface can_tx_mailbox_if #(
    parameter int NUM_MB = 10,
    parameter int ID_W   = 11
);
    localparam int MBW = $clog2(NUM_MB);

    logic            frame_gen_intl;
    logic            fg_ack;
    logic [ID_W-1:0] tx_id;
    logic            tx_rtr;
    logic [3:0]      tx_dlc;
    logic [63:0]     tx_data;
    logic [MBW-1:0]  tx_mb;
    logic            tx_success;
    logic            tx_fail;

    modport master (
        output frame_gen_intl, tx_id, tx_rtr, tx_dlc, tx_data, tx_mb,
        input  fg_ack, tx_success, tx_fail
    );

    modport slave (
        input  frame_gen_intl, tx_id, tx_rtr, tx_dlc, tx_data, tx_mb,
        output fg_ack, tx_success, tx_fail
    );
endinterface

// File: rtl/can_tx_mailbox_prio_sel.sv
// Picks the pending mailbox with the lowest identifier; ties go to the lowest index.
// Latency: combinational.
// Backpressure: none; the result is sampled by the caller in its ARB state.
// Ports: pending_i (pending mask), ids_i (zero-extended ids), vld_o (any pending), idx_o (winner).
module can_tx_prio_sel
    import can_tx_pkg::*;
#(
    parameter  int NUM_MB = 10,
    localparam int MBW    = $clog2(NUM_MB)
) (
    input  logic [NUM_MB-1:0]               pending_i,
    input  logic [NUM_MB-1:0][MAX_ID_W-1:0] ids_i,
    output logic                            vld_o,
    output logic [MBW-1:0]                  idx_o
);
    logic                found;
    logic [MAX_ID_W-1:0] best_id;
    logic [MBW-1:0]      best_idx;

    // A strict '<' means a later mailbox with an equal id never displaces
    // an earlier one, so ties resolve to the lowest index.
    always_comb begin
        found    = 1'b0;
        best_id  = '1;
        best_idx = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            if (pending_i[i] && (!found || (ids_i[i] < best_id))) begin
                found    = 1'b1;
                best_id  = ids_i[i];
                best_idx = MBW'(i);
            end
        end
    end

    assign vld_o = found;
    assign idx_o = best_idx;
endmodule

// File: rtl/can_tx_mailbox.sv
// Multi-mailbox CAN transmit buffer: lowest-id pending frame goes to the frame generator; failed frames retry after re-arbitration.
// Latency: commit -> request in 3 cycles; tx_fail -> next request in 3 cycles; tx_success -> tx_done next cycle.
// Backpressure: the request is held until fg_ack; host writes to a pending mailbox are dropped.
// Optional retry limit: CAN_TX_RETRY_LIMIT_EN (drop after MAX_RETRY failures, pulse tx_err).
// Ports: host writes (hdr_ld/hdr_*, wr_en/wr_mb/wr_idx/data_in); commit tx_buff_ld.
// Ports: status mb_pending/tx_buff_busy; results tx_done/tx_done_mb/tx_err; frame generator link fg.
module can_tx_mailbox
    import can_tx_pkg::*;
#(
    parameter  int NUM_MB    = 10,
    parameter  int ID_W      = 11,
    parameter  int MAX_RETRY = 16,
    localparam int MBW       = $clog2(NUM_MB)
) (
    input  logic              clk,
    input  logic              g_rst,
    input  logic              hdr_ld,
    input  logic [ID_W-1:0]   hdr_id,
    input  logic              hdr_rtr,
    input  logic [3:0]        hdr_dlc,
    input  logic              wr_en,
    input  logic [MBW-1:0]    wr_mb,
    input  logic [2:0]        wr_idx,
    input  logic [7:0]        data_in,
    input  logic [NUM_MB-1:0] tx_buff_ld,
    output logic [NUM_MB-1:0] mb_pending,
    output logic              tx_buff_busy,
    output logic              tx_done,
    output logic [MBW-1:0]    tx_done_mb,
    output logic              tx_err,
    can_tx_mailbox_if.master  fg
);
    if (NUM_MB < 2 || NUM_MB > 16 || ID_W < 1 || ID_W > MAX_ID_W || MAX_RETRY < 1) begin : g_param_check
        $error("can_tx_mailbox: parameter out of range");
    end

    state_t                          state_q, state_d;
    logic [NUM_MB-1:0]               pending_q, pending_d;
    hdr_t                            hdr_q  [NUM_MB];
    logic [7:0]                      data_q [NUM_MB][MAX_BYTES];
    logic [NUM_MB-1:0][MAX_ID_W-1:0] ids;
    logic                            sel_vld;
    logic [MBW-1:0]                  sel_idx;
    logic [63:0]                     sel_payload;
    logic [ID_W-1:0]                 tx_id_q;
    logic                            tx_rtr_q;
    logic [3:0]                      tx_dlc_q;
    logic [63:0]                     tx_data_q;
    logic [MBW-1:0]                  tx_mb_q;
    logic                            tx_done_q;
    logic [MBW-1:0]                  tx_done_mb_q;
    logic                            arb_load, tx_ok, tx_bad, drop, wr_ok;

    always_comb begin
        for (int i = 0; i < NUM_MB; i++) begin
            ids[i] = hdr_q[i].id;
        end
    end

    can_tx_prio_sel #(.NUM_MB(NUM_MB)) u_prio_sel (
        .pending_i (pending_q),
        .ids_i     (ids),
        .vld_o     (sel_vld),
        .idx_o     (sel_idx)
    );

    always_comb begin
        sel_payload = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            sel_payload[8*k +: 8] = data_q[sel_idx][k];
        end
    end

    always_ff @(posedge clk) begin
        if (!g_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // tx_success/tx_fail are only looked at in WAIT; success has priority.
    always_comb begin
        state_d  = state_q;
        arb_load = 1'b0;
        tx_ok    = 1'b0;
        tx_bad   = 1'b0;
        case (state_q)
            IDLE: if (|pending_q) state_d = ARB;
            ARB: begin
                if (sel_vld) begin
                    arb_load = 1'b1;
                    state_d  = REQ;
                end else begin
                    state_d  = IDLE;
                end
            end
            REQ:  if (fg.fg_ack) state_d = WAIT;
            WAIT: begin
                if (fg.tx_success) begin
                    tx_ok   = 1'b1;
                    state_d = IDLE;
                end else if (fg.tx_fail) begin
                    tx_bad  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CAN_TX_RETRY_LIMIT_EN
    localparam int RW = $clog2(MAX_RETRY + 1);
    logic [RW-1:0] retry_q [NUM_MB];
    logic          tx_err_q;

    // The failure that would make the count reach MAX_RETRY drops the frame.
    assign drop = tx_bad && (retry_q[tx_mb_q] == RW'(MAX_RETRY - 1));

    always_ff @(posedge clk) begin
        if (!g_rst) begin
            tx_err_q <= 1'b0;
            for (int i = 0; i < NUM_MB; i++) retry_q[i] <= '0;
        end else begin
            tx_err_q <= drop;
            if (tx_ok || drop)  retry_q[tx_mb_q] <= '0;
            else if (tx_bad)    retry_q[tx_mb_q] <= retry_q[tx_mb_q] + 1'b1;
        end
    end
    assign tx_err = tx_err_q;
`else
    assign drop   = 1'b0;
    assign tx_err = 1'b0;
`endif

    // Clearing is applied after the commit OR, so a re-commit of the
    // mailbox being retired in the same cycle does not resurrect it.
    always_comb begin
        pending_d = pending_q | tx_buff_ld;
        if (tx_ok || drop) pending_d[tx_mb_q] = 1'b0;
    end

    assign wr_ok = (32'(wr_mb) < NUM_MB) && !pending_q[wr_mb];

    always_ff @(posedge clk) begin
        if (!g_rst) begin
            pending_q    <= '0;
            tx_done_q    <= 1'b0;
            tx_done_mb_q <= '0;
            tx_id_q      <= '0;
            tx_rtr_q     <= 1'b0;
            tx_dlc_q     <= '0;
            tx_data_q    <= '0;
            tx_mb_q      <= '0;
            for (int i = 0; i < NUM_MB; i++) begin
                hdr_q[i] <= '0;
                for (int k = 0; k < MAX_BYTES; k++) data_q[i][k] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            tx_done_q <= tx_ok;
            if (tx_ok) tx_done_mb_q <= tx_mb_q;
            if (wr_ok && hdr_ld) hdr_q[wr_mb] <= '{id: MAX_ID_W'(hdr_id), rtr: hdr_rtr, dlc: hdr_dlc};
            if (wr_ok && wr_en)  data_q[wr_mb][wr_idx] <= data_in;
            if (arb_load) begin
                tx_id_q   <= hdr_q[sel_idx].id[ID_W-1:0];
                tx_rtr_q  <= hdr_q[sel_idx].rtr;
                tx_dlc_q  <= hdr_q[sel_idx].dlc;
                tx_data_q <= sel_payload;
                tx_mb_q   <= sel_idx;
            end
        end
    end

    assign mb_pending        = pending_q;
    assign tx_buff_busy      = |pending_q;
    assign tx_done           = tx_done_q;
    assign tx_done_mb        = tx_done_mb_q;
    assign fg.frame_gen_intl = (state_q == REQ);
    assign fg.tx_id          = tx_id_q;
    assign fg.tx_rtr         = tx_rtr_q;
    assign fg.tx_dlc         = tx_dlc_q;
    assign fg.tx_data        = tx_data_q;
    assign fg.tx_mb          = tx_mb_q;
endmodule

// File: tb/tb_can_tx_mailbox.sv
module tb_can_tx_mailbox;
    localparam int NUM_MB = 10;
    localparam int ID_W   = 11;
    localparam int MBW    = 4;

    logic              clk = 1'b0;
    logic              g_rst;
    logic              hdr_ld, hdr_rtr, wr_en;
    logic [ID_W-1:0]   hdr_id;
    logic [3:0]        hdr_dlc;
    logic [MBW-1:0]    wr_mb;
    logic [2:0]        wr_idx;
    logic [7:0]        data_in;
    logic [NUM_MB-1:0] tx_buff_ld, mb_pending;
    logic              tx_buff_busy, tx_done, tx_err;
    logic [MBW-1:0]    tx_done_mb;

    int checks = 0;
    int errors = 0;
    logic [MBW-1:0]  got_mb;
    logic [ID_W-1:0] got_id;

    can_tx_mailbox_if #(.NUM_MB(NUM_MB), .ID_W(ID_W)) fg_if ();

    can_tx_mailbox #(.NUM_MB(NUM_MB), .ID_W(ID_W), .MAX_RETRY(3)) dut (
        .clk(clk), .g_rst(g_rst),
        .hdr_ld(hdr_ld), .hdr_id(hdr_id), .hdr_rtr(hdr_rtr), .hdr_dlc(hdr_dlc),
        .wr_en(wr_en), .wr_mb(wr_mb), .wr_idx(wr_idx), .data_in(data_in),
        .tx_buff_ld(tx_buff_ld), .mb_pending(mb_pending), .tx_buff_busy(tx_buff_busy),
        .tx_done(tx_done), .tx_done_mb(tx_done_mb), .tx_err(tx_err),
        .fg(fg_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_mb(input int mb, input logic [ID_W-1:0] id, input logic rtr,
                           input logic [3:0] dlc, input logic [63:0] payload);
        for (int k = 0; k < 8; k++) begin
            wr_mb   = MBW'(mb);
            wr_idx  = 3'(k);
            data_in = payload[8*k +: 8];
            wr_en   = 1'b1;
            hdr_ld  = (k == 0);
            hdr_id  = id;
            hdr_rtr = rtr;
            hdr_dlc = dlc;
            tick();
        end
        wr_en  = 1'b0;
        hdr_ld = 1'b0;
    endtask

    task automatic commit(input logic [NUM_MB-1:0] mask);
        tx_buff_ld = mask;
        tick();
        tx_buff_ld = '0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!fg_if.frame_gen_intl && n < 20) begin
            tick();
            n++;
        end
        check(tag, 64'(fg_if.frame_gen_intl), 64'd1);
    endtask

    task automatic ack();
        fg_if.fg_ack = 1'b1;
        tick();
        fg_if.fg_ack = 1'b0;
    endtask

    task automatic send_ok(input string tag, output logic [MBW-1:0] mb_o, output logic [ID_W-1:0] id_o);
        wait_req(tag);
        mb_o = fg_if.tx_mb;
        id_o = fg_if.tx_id;
        ack();
        fg_if.tx_success = 1'b1;
        tick();
        fg_if.tx_success = 1'b0;
        check({tag, "_done"}, 64'(tx_done), 64'd1);
    endtask

    task automatic fail_once();
        fg_if.tx_fail = 1'b1;
        tick();
        fg_if.tx_fail = 1'b0;
    endtask

    initial begin
        g_rst = 1'b0; hdr_ld = 0; hdr_rtr = 0; wr_en = 0; hdr_id = '0; hdr_dlc = '0;
        wr_mb = '0; wr_idx = '0; data_in = '0; tx_buff_ld = '0;
        fg_if.fg_ack = 0; fg_if.tx_success = 0; fg_if.tx_fail = 0;
        repeat (3) tick();
        g_rst = 1'b1;
        tick();

        // Reset state
        check("rst_pending", 64'(mb_pending), 64'd0);
        check("rst_busy",    64'(tx_buff_busy), 64'd0);
        check("rst_intl",    64'(fg_if.frame_gen_intl), 64'd0);
        check("rst_done",    64'(tx_done), 64'd0);
        check("rst_err",     64'(tx_err), 64'd0);
        check("rst_data",    fg_if.tx_data, 64'd0);

        // Single frame, commit timing
        load_mb(3, 11'h123, 1'b0, 4'd2, 64'h0000_0000_0000_BBAA);
        commit(10'b00_0000_1000);
        check("t1_pending", 64'(mb_pending), 64'h8);
        check("t1_busy",    64'(tx_buff_busy), 64'd1);
        check("t1_intl_n1", 64'(fg_if.frame_gen_intl), 64'd0);
        tick();
        check("t1_intl_n2", 64'(fg_if.frame_gen_intl), 64'd0);
        tick();
        check("t1_intl_n3", 64'(fg_if.frame_gen_intl), 64'd1);
        check("t1_id",      64'(fg_if.tx_id), 64'h123);
        check("t1_data",    64'(fg_if.tx_data[15:0]), 64'hBBAA);
        check("t1_dlc",     64'(fg_if.tx_dlc), 64'd2);
        check("t1_mb",      64'(fg_if.tx_mb), 64'd3);
        // tx_success outside WAIT is ignored
        fg_if.tx_success = 1'b1;
        tick();
        fg_if.tx_success = 1'b0;
        check("t1_ign_intl", 64'(fg_if.frame_gen_intl), 64'd1);
        check("t1_ign_done", 64'(tx_done), 64'd0);
        ack();
        check("t1_intl_drop", 64'(fg_if.frame_gen_intl), 64'd0);
        fg_if.tx_success = 1'b1;
        tick();
        fg_if.tx_success = 1'b0;
        check("t1_done",    64'(tx_done), 64'd1);
        check("t1_done_mb", 64'(tx_done_mb), 64'd3);
        check("t1_pend_clr", 64'(mb_pending), 64'd0);
        tick();
        check("t1_done_pulse", 64'(tx_done), 64'd0);

        // Priority: lower id first; dlc 15 passes through
        load_mb(0, 11'h300, 1'b0, 4'd15, 64'h0807_0605_0403_0201);
        load_mb(5, 11'h100, 1'b0, 4'd1,  64'h0000_0000_0000_0055);
        commit(10'b00_0010_0001);
        wait_req("t2_req_a");
        check("t2_dlc_a", 64'(fg_if.tx_dlc), 64'd1);
        send_ok("t2_a", got_mb, got_id);
        check("t2_mb_a", 64'(got_mb), 64'd5);
        check("t2_id_a", 64'(got_id), 64'h100);
        wait_req("t2_req_b");
        check("t2_dlc_b",  64'(fg_if.tx_dlc), 64'd15);
        check("t2_data_b", fg_if.tx_data, 64'h0807_0605_0403_0201);
        send_ok("t2_b", got_mb, got_id);
        check("t2_mb_b", 64'(got_mb), 64'd0);

        // Equal ids: lowest index wins; rtr passes through
        load_mb(7, 11'h200, 1'b1, 4'd0, 64'h0);
        load_mb(2, 11'h200, 1'b0, 4'd8, 64'h1111_1111_1111_1111);
        commit(10'b00_1000_0100);
        send_ok("t2_tie_a", got_mb, got_id);
        check("t2_tie_mb_a", 64'(got_mb), 64'd2);
        wait_req("t2_tie_req_b");
        check("t2_tie_rtr", 64'(fg_if.tx_rtr), 64'd1);
        send_ok("t2_tie_b", got_mb, got_id);
        check("t2_tie_mb_b", 64'(got_mb), 64'd7);

        // Preemption after failure; writes to pending mailbox ignored
        load_mb(1, 11'h400, 1'b0, 4'd3, 64'h0000_0000_00CC_DDEE);
        commit(10'b00_0000_0010);
        wait_req("t3_req1");
        check("t3_mb1", 64'(fg_if.tx_mb), 64'd1);
        ack();
        load_mb(4, 11'h010, 1'b0, 4'd1, 64'h77);
        load_mb(1, 11'h7FF, 1'b1, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF);
        commit(10'b00_0001_0010);
        fail_once();
        check("t3_pend_after_fail", 64'(mb_pending), 64'h12);
        check("t3_no_done", 64'(tx_done), 64'd0);
        send_ok("t3_pre", got_mb, got_id);
        check("t3_pre_mb", 64'(got_mb), 64'd4);
        wait_req("t3_req_retry");
        check("t3_retry_mb",   64'(fg_if.tx_mb), 64'd1);
        check("t3_retry_id",   64'(fg_if.tx_id), 64'h400);
        check("t3_retry_data", fg_if.tx_data, 64'h0000_0000_00CC_DDEE);
        check("t3_retry_dlc",  64'(fg_if.tx_dlc), 64'd3);
        ack();
        // success and fail together: success wins
        fg_if.tx_success = 1'b1;
        fg_if.tx_fail    = 1'b1;
        tick();
        fg_if.tx_success = 1'b0;
        fg_if.tx_fail    = 1'b0;
        check("t3_both_done", 64'(tx_done), 64'd1);
        check("t3_both_mb",   64'(tx_done_mb), 64'd1);
        check("t3_both_pend", 64'(mb_pending), 64'd0);

        // Retry behaviour
        load_mb(6, 11'h055, 1'b0, 4'd0, 64'h0);
        commit(10'b00_0100_0000);
`ifdef CAN_TX_RETRY_LIMIT_EN
        for (int r = 0; r < 3; r++) begin
            wait_req("t5_req");
            ack();
            fail_once();
            check("t5_done", 64'(tx_done), 64'd0);
            check("t5_err", 64'(tx_err), (r == 2) ? 64'd1 : 64'd0);
        end
        check("t5_dropped", 64'(mb_pending), 64'd0);
        tick();
        check("t5_err_pulse", 64'(tx_err), 64'd0);
        repeat (3) tick();
        check("t5_no_req", 64'(fg_if.frame_gen_intl), 64'd0);
`else
        for (int r = 0; r < 20; r++) begin
            wait_req("t5_req");
            check("t5_mb", 64'(fg_if.tx_mb), 64'd6);
            ack();
            fail_once();
            check("t5_pend", 64'(mb_pending), 64'h40);
            check("t5_err", 64'(tx_err), 64'd0);
        end
        send_ok("t5_final", got_mb, got_id);
        check("t5_final_mb", 64'(got_mb), 64'd6);
`endif

        // Reset during WAIT
        load_mb(8, 11'h222, 1'b1, 4'd4, 64'hDEAD_BEEF);
        commit(10'b01_0000_0000);
        wait_req("t6_req");
        ack();
        g_rst = 1'b0;
        fg_if.tx_success = 1'b1;
        tick();
        fg_if.tx_success = 1'b0;
        check("t6_pending", 64'(mb_pending), 64'd0);
        check("t6_busy",    64'(tx_buff_busy), 64'd0);
        check("t6_intl",    64'(fg_if.frame_gen_intl), 64'd0);
        check("t6_done",    64'(tx_done), 64'd0);
        check("t6_done_mb", 64'(tx_done_mb), 64'd0);
        check("t6_id",      64'(fg_if.tx_id), 64'd0);
        check("t6_rtr",     64'(fg_if.tx_rtr), 64'd0);
        check("t6_dlc",     64'(fg_if.tx_dlc), 64'd0);
        check("t6_data",    fg_if.tx_data, 64'd0);
        check("t6_mb",      64'(fg_if.tx_mb), 64'd0);
        check("t6_err",     64'(tx_err), 64'd0);
        g_rst = 1'b1;
        tick();
        check("t6_post_done", 64'(tx_done), 64'd0);
        // contents of mailbox 8 were cleared by reset
        commit(10'b01_0000_0000);
        wait_req("t6_req2");
        check("t6_cleared_id",   64'(fg_if.tx_id), 64'd0);
        check("t6_cleared_data", fg_if.tx_data, 64'd0);
        check("t6_cleared_rtr",  64'(fg_if.tx_rtr), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
